// File: rtl/modulus_fold_seq_pkg.sv
// Shared types, helpers and the modulus definition for the fold sequencer.
// The modulus is a macro of the width so every instance agrees on M.
`ifndef MODULUS_DEF
`define MODULUS_DEF(w) ((((w)+1)'(1) << (w)) - (((w)+1)'(1) << ((w)/3)) - ((w)+1)'(1))
`endif

package msu_fold_pkg;

    localparam int DIGIT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } fold_state_t;

    function automatic int acc_width(input int mod_w, input int num_hex);
        return mod_w + $clog2(num_hex + 1);
    endfunction

endpackage

// File: rtl/modulus_fold_seq_hex.sv
// modulus_hex: 64-entry ROM giving (digit << CUR_LOW_POS) mod M.
// Table contents are fixed at elaboration from the modulus macro.
module modulus_hex
    import msu_fold_pkg::*;
#(
    parameter int MODULUS_WIDTH = 1024,
    parameter int CUR_LOW_POS   = 1024
) (
    input  logic [DIGIT_W-1:0]       digit,
    output logic [MODULUS_WIDTH-1:0] term
);

    localparam int XW = CUR_LOW_POS + DIGIT_W + 8;
    localparam logic [XW-1:0] MODX = XW'(`MODULUS_DEF(MODULUS_WIDTH));

    logic [MODULUS_WIDTH-1:0] rom [64];

    for (genvar j = 0; j < 64; j++) begin : g_rom
        localparam logic [XW-1:0] PROD = XW'(j) << CUR_LOW_POS;
        localparam logic [XW-1:0] RES  = PROD % MODX;
        assign rom[j] = RES[MODULUS_WIDTH-1:0];
    end

    assign term = rom[digit];

endmodule

// File: rtl/modulus_fold_seq.sv
// modulus_fold_seq: folds the high digits of in_data into a W-bit residue
// sum, one digit per cycle, behind a valid/ready pair on each side.
module modulus_fold_seq
    import msu_fold_pkg::*;
#(
    parameter int MODULUS_WIDTH = 1024,
    parameter int NUM_HEX       = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [MODULUS_WIDTH+DIGIT_W*NUM_HEX-1:0]    in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [acc_width(MODULUS_WIDTH,NUM_HEX)-1:0] out_data
);

    localparam int ACC_W = acc_width(MODULUS_WIDTH, NUM_HEX);
    localparam int KW    = (NUM_HEX == 1) ? 1 : $clog2(NUM_HEX);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_HEX - 1);

    fold_state_t              state;
    logic [ACC_W-1:0]         acc;
    logic [KW-1:0]            k;
    logic [DIGIT_W-1:0]       digits [NUM_HEX];
    logic [MODULUS_WIDTH-1:0] terms  [NUM_HEX];
    logic [MODULUS_WIDTH-1:0] term_sel;

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
        modulus_hex #(
            .MODULUS_WIDTH (MODULUS_WIDTH),
            .CUR_LOW_POS   (MODULUS_WIDTH + DIGIT_W * g)
        ) u_hex (
            .digit (digits[g]),
            .term  (terms[g])
        );
    end

    assign term_sel = terms[k];
    assign out_data = acc;

    // in_ready/out_valid are registered so both read 0 while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < NUM_HEX; i++) begin
                digits[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= ACC_W'(in_data[MODULUS_WIDTH-1:0]);
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= FOLD;
                        for (int i = 0; i < NUM_HEX; i++) begin
                            digits[i] <= in_data[MODULUS_WIDTH+DIGIT_W*i +: DIGIT_W];
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                FOLD: begin
                    acc <= acc + ACC_W'(term_sel);
                    if (k == K_LAST) begin
                        k         <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulus_fold_seq.sv
// Bench for modulus_fold_seq: scoreboard of expected folds, popped on
// every output handshake, plus directed latency/stall/reset scenarios.
module tb_modulus_fold_seq;

    localparam int W     = 1024;
    localparam int N     = 4;
    localparam int IN_W  = W + 6 * N;
    localparam int ACC_W = W + $clog2(N + 1);
    localparam int XW    = IN_W + 8;
    localparam logic [XW-1:0] ONE  = 1;
    localparam logic [XW-1:0] MODX = (ONE << W) - (ONE << (W / 3)) - ONE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_data;

    int passed = 0;
    int total = 0;

    logic [ACC_W-1:0] exp_q [$];
    logic [IN_W-1:0]  src_q [$];

    always #5 clk = ~clk;

    modulus_fold_seq #(
        .MODULUS_WIDTH (W),
        .NUM_HEX       (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [ACC_W-1:0] ref_fold(input logic [IN_W-1:0] x);
        logic [ACC_W-1:0] a;
        logic [XW-1:0]    t;
        a = ACC_W'(x[W-1:0]);
        for (int i = 0; i < N; i++) begin
            t = XW'(x[W+6*i +: 6]) << (W + 6 * i);
            t = t % MODX;
            a = a + ACC_W'(t);
        end
        return a;
    endfunction

    function automatic logic [IN_W-1:0] rand_in();
        logic [IN_W+31:0] r;
        r = '0;
        for (int i = 0; i < (IN_W + 31) / 32; i++) begin
            r[32*i +: 32] = $urandom;
        end
        return r[IN_W-1:0];
    endfunction

    // Scoreboard: every accepted output is compared exactly and by residue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [ACC_W-1:0] e;
            logic [IN_W-1:0]  s;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got out_data lo=%h want no output",
                         out_data[127:0]);
            end else begin
                e = exp_q.pop_front();
                s = src_q.pop_front();
                if (out_data !== e)
                    $display("FAIL sb_data: got hi=%h lo=%h want hi=%h lo=%h",
                             out_data[ACC_W-1:ACC_W-64], out_data[127:0],
                             e[ACC_W-1:ACC_W-64], e[127:0]);
                else
                    passed++;
                total++;
                if ((XW'(out_data) % MODX) !== (XW'(s) % MODX))
                    $display("FAIL sb_congruent: got lo=%h want lo=%h",
                             out_data[127:0], s[127:0]);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] x);
        int n;
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
            in_valid = 1'b0;
            tick();
        end else begin
            @(posedge clk);
            exp_q.push_back(ref_fold(x));
            src_q.push_back(x);
            #1;
            in_valid = 1'b0;
            in_data  = rand_in();
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready);
        else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
        else passed++;
        total++;
        if (out_data !== '0) $display("FAIL rst_out_data: got lo=%h want 0", out_data[63:0]);
        else passed++;
        repeat (2) tick();
        total++;
        if (in_ready !== 1'b0) $display("FAIL rst_held_ready: got %b want 0", in_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) $display("FAIL rst_first_edge: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_low_only();
        logic [IN_W-1:0] x;
        int cyc;
        x = '0;
        x[15:0] = 16'h1234;
        send(x);
        total++;
        if (in_ready !== 1'b0) $display("FAIL fold_in_ready: got %b want 0", in_ready);
        else passed++;
        wait_valid(cyc);
        total++;
        if (cyc !== N + 1) $display("FAIL latency: got %0d want %0d", cyc, N + 1);
        else passed++;
        total++;
        if (out_data !== ACC_W'(16'h1234))
            $display("FAIL low_only: got lo=%h want lo=%h", out_data[63:0], 64'h1234);
        else passed++;
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL post_handshake: got in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_digit0();
        logic [IN_W-1:0]  x;
        logic [ACC_W-1:0] e;
        int cyc;
        x = '0;
        x[W] = 1'b1;
        e = '0;
        e[W/3] = 1'b1;
        e[0] = 1'b1;
        send(x);
        wait_valid(cyc);
        total++;
        if (out_valid !== 1'b1 || out_data !== e)
            $display("FAIL digit0: got v=%b lo=%h hi=%h want lo=%h hi=%h",
                     out_valid, out_data[63:0], out_data[ACC_W-1:ACC_W-700],
                     e[63:0], e[ACC_W-1:ACC_W-700]);
        else passed++;
        release_out();
    endtask

    task automatic test_max();
        logic [IN_W-1:0] x;
        int cyc;
        x = '1;
        send(x);
        wait_valid(cyc);
        total++;
        if (out_data !== ref_fold(x))
            $display("FAIL max_sum: got lo=%h want lo=%h", out_data[127:0],
                     ref_fold(x) >> 0);
        else passed++;
        total++;
        if (out_data[ACC_W-1:W] === '0)
            $display("FAIL max_carry: got top=%b want nonzero", out_data[ACC_W-1:W]);
        else passed++;
        release_out();
    endtask

    task automatic test_stall();
        logic [ACC_W-1:0] held;
        int cyc;
        int bad;
        send(rand_in());
        wait_valid(cyc);
        held = out_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = rand_in();
            tick();
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        else passed++;
        release_out();
        total++;
        if (exp_q.size() !== 0)
            $display("FAIL stall_ignored: got %0d pending want 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_abort();
        logic [IN_W-1:0] x;
        int cyc;
        int bad;
        send(rand_in());
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0)
            $display("FAIL abort_reset: got v=%b r=%b lo=%h want 0 0 0",
                     out_valid, in_ready, out_data[63:0]);
        else passed++;
        exp_q.delete();
        src_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        out_ready = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL abort_no_out: got %0d valid cycles want 0", bad);
        else passed++;
        x = rand_in();
        send(x);
        wait_valid(cyc);
        total++;
        if (out_data !== ref_fold(x))
            $display("FAIL abort_next: got lo=%h want lo=%h",
                     out_data[127:0], ref_fold(x) >> 0);
        else passed++;
        release_out();
    endtask

    task automatic test_back_to_back();
        bit done;
        int n;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    send(rand_in());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        total++;
        if (exp_q.size() !== 0)
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_low_only();
        test_digit0();
        test_max();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
